// File: rtl/regfile_dump_pkg.sv
// Shared types and frame geometry for the register-file dump reader.
package regfile_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;
  localparam int FRAME_BYTES    = BYTES_PER_WORD + 1;

  // Header byte plus the word split into bytes.
  function automatic int frame_bytes(input int data_width, input int byte_width);
    return data_width / byte_width + 1;
  endfunction

endpackage

// File: rtl/dump_byte_serializer.sv
// Holds one header+word frame and emits it byte by byte, header first,
// then the word least-significant byte first, over a valid/ready handshake.
module dump_byte_serializer
  import regfile_dump_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [BYTE_WIDTH-1:0] header_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [BYTE_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_done_o
);

  localparam int FRAME_N = frame_bytes(DATA_WIDTH, BYTE_WIDTH);
  localparam int FRAME_W = FRAME_N * BYTE_WIDTH;
  localparam int IDX_W   = $clog2(FRAME_N);

  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               xfer, last_byte;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    frame_d   = frame_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    xfer      = valid_q & ready_i;
    last_byte = (idx_q == IDX_W'(FRAME_N - 1));
    if (load_i) begin
      frame_d = {word_i, header_i};
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (xfer) begin
      frame_d = frame_q >> BYTE_WIDTH;
      idx_d   = idx_q + 1'b1;
      if (last_byte) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: the frame shift register is left unreset; data_o is masked by valid_q, so stale contents never escape.
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign valid_o      = valid_q;
  assign data_o       = valid_q ? frame_q[BYTE_WIDTH-1:0] : '0;
  assign frame_done_o = xfer & last_byte;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a contiguous (possibly wrapping) register range through a spare read
// port and streams each register as a header+data byte frame.
module regfile_dump_reader
  import regfile_dump_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_DEPTH  = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_first_addr,
  input  logic [ADDR_WIDTH-1:0] i_last_addr,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  output logic                  o_freeze,
  output logic [BYTE_WIDTH-1:0] o_byte_data,
  output logic                  o_byte_valid,
  input  logic                  i_byte_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(REG_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic                  load;
  logic                  frame_done;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          addr_d  = i_first_addr;
          last_d  = i_last_addr;
          state_d = FETCH;
        end
      end
      FETCH: begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (frame_done) begin
          if (addr_q == last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = (addr_q == TOP_ADDR) ? '0 : addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        // Return the read address to 0 so every output is quiet in IDLE.
        addr_d  = '0;
        last_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  dump_byte_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_serializer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .header_i    (BYTE_WIDTH'(addr_q)),
    .word_i      (i_rf_data),
    .data_o      (o_byte_data),
    .valid_o     (o_byte_valid),
    .ready_i     (i_byte_ready),
    .frame_done_o(frame_done)
  );

  assign o_rf_addr = addr_q;
  assign o_freeze  = (state_q == FETCH) || (state_q == SEND);
  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);

endmodule
